// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the sequencer state enum, the special opcodes and the per-register control bundle.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [3:0] HLT_OP = 4'hF;
  localparam logic [3:0] LW_OP  = 4'h8;

  // Write enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
  typedef struct packed {
    logic pc_wen;
    logic ifid_wen;
    logic ifid_flush;
    logic idex_wen;
    logic idex_bubble;
    logic exmem_wen;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE     = 7'b000_0000;
  localparam ctrl_t CTRL_RUN      = 7'b110_1010;
  localparam ctrl_t CTRL_MEMSTALL = 7'b000_0001;
  localparam ctrl_t CTRL_LOADUSE  = 7'b000_1110;
  localparam ctrl_t CTRL_BRANCH   = 7'b111_1010;
  localparam ctrl_t CTRL_DRAIN    = 7'b011_1010;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
// Used for the memory-wait counter and the optional performance counters.
module sat_counter #(
  parameter int unsigned     WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign at_max = (count_q == MAX);
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, memory freeze, HLT drain.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_count saturating counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ifid_opcode,
  input  logic [3:0]  ifid_rs,
  input  logic [3:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        idex_memread,
  input  logic [3:0]  idex_rd,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic        idex_wen,
  output logic        idex_bubble,
  output logic        exmem_wen,
  output logic        memwb_bubble,
  output logic        halted,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0]  DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic        mem_timeout_q, mem_timeout_d;
  ctrl_t       ctrl;

  logic              mem_stall;
  logic              load_use;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_at_max;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = idex_memread & (idex_rd != 4'd0) &
                     ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));

  sat_counter #(
    .WIDTH (WAIT_W),
    .MAX   (WAIT_W'(MEM_TIMEOUT))
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (mem_stall),
    .clr    (~mem_stall),
    .count  (wait_cnt),
    .at_max (wait_at_max)
  );

  // Timeout latches one cycle after the wait counter reaches its limit.
  assign mem_timeout_d = mem_timeout_q | (wait_at_max & (|wait_cnt));

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    ctrl    = CTRL_NONE;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (mem_stall) begin
            ctrl = CTRL_MEMSTALL;
          end else if (load_use) begin
            ctrl = CTRL_LOADUSE;
          end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
          end else if (ifid_opcode == HLT_OP) begin
            ctrl    = CTRL_DRAIN;
            state_d = DRAIN;
            drain_d = 3'd0;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        DRAIN: begin
          // Hazards from instructions behind HLT are irrelevant; only the memory freeze matters.
          if (mem_stall) begin
            ctrl = CTRL_MEMSTALL;
          end else begin
            ctrl = CTRL_DRAIN;
            if (drain_q == DRAIN_LAST) begin
              state_d = HALT;
            end else begin
              drain_d = drain_q + 3'd1;
            end
          end
        end
        HALT: begin
          ctrl = CTRL_NONE;
        end
        default: begin
          state_d = RUN;
          drain_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      drain_q       <= 3'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_wen       = ctrl.pc_wen;
  assign ifid_wen     = ctrl.ifid_wen;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_wen     = ctrl.idex_wen;
  assign idex_bubble  = ctrl.idex_bubble;
  assign exmem_wen    = ctrl.exmem_wen;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign halted       = (state_q == HALT) & ~rst;
  assign mem_timeout  = mem_timeout_q & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, flush_inc;
  logic stall_at_max, flush_at_max;

  // Count only cycles where a stall actually takes effect (load-use is ignored while draining).
  assign stall_inc = ~rst & (state_q != HALT) &
                     (mem_stall | ((state_q == RUN) & load_use));
  assign flush_inc = ~rst & (state_q == RUN) & ctrl.ifid_flush & branch_taken;

  sat_counter #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (stall_inc),
    .clr    (1'b0),
    .count  (stall_cycles),
    .at_max (stall_at_max)
  );

  sat_counter #(
    .WIDTH (16)
  ) u_flush_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (flush_inc),
    .clr    (1'b0),
    .count  (flush_count),
    .at_max (flush_at_max)
  );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (DRAIN_CYCLES=3, MEM_TIMEOUT=4), directed vectors.
// Driver pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] ifid_opcode, ifid_rs, ifid_rt, idex_rd;
  logic       ifid_uses_rt, idex_memread, branch_taken, mem_req, mem_ready;
  logic       pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_wen, memwb_bubble;
  logic       halted, mem_timeout;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES (3),
    .MEM_TIMEOUT  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_opcode  (ifid_opcode),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_rd      (idex_rd),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_wen       (pc_wen),
    .ifid_wen     (ifid_wen),
    .ifid_flush   (ifid_flush),
    .idex_wen     (idex_wen),
    .idex_bubble  (idex_bubble),
    .exmem_wen    (exmem_wen),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: pc_wen ifid_wen ifid_flush idex_wen idex_bubble exmem_wen memwb_bubble halted mem_timeout
  localparam logic [8:0] E_ZERO = 9'b0000000_00;
  localparam logic [8:0] E_RUN  = 9'b1101010_00;
  localparam logic [8:0] E_MST  = 9'b0000001_00;
  localparam logic [8:0] E_LU   = 9'b0001110_00;
  localparam logic [8:0] E_BR   = 9'b1111010_00;
  localparam logic [8:0] E_DRN  = 9'b0111010_00;
  localparam logic [8:0] E_HALT = 9'b0000000_10;
  localparam logic [8:0] E_TO   = 9'b0000000_01;
  localparam logic [8:0] M_ALL  = 9'h1FF;
  localparam logic [8:0] M_NOTO = 9'h1FE;
  localparam logic [8:0] M_RST  = 9'h1FC;

  typedef struct {
    logic [8:0] exp;
    logic [8:0] mask;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       s_rst, s_ur, s_mr, s_br, s_mq, s_my;
  logic [3:0] s_op, s_rs, s_rt, s_rd;

  task automatic idle_in();
    s_rst = 1'b0; s_op = 4'h0; s_rs = 4'h1; s_rt = 4'h2; s_ur = 1'b0;
    s_mr = 1'b0; s_rd = 4'h0; s_br = 1'b0; s_mq = 1'b0; s_my = 1'b0;
  endtask

  // Apply the staged inputs for one cycle and register what that cycle must show.
  task automatic cyc(input logic [8:0] ex, input logic [8:0] mk, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s_rst; ifid_opcode = s_op; ifid_rs = s_rs; ifid_rt = s_rt; ifid_uses_rt = s_ur;
    idex_memread = s_mr; idex_rd = s_rd; branch_taken = s_br; mem_req = s_mq; mem_ready = s_my;
    e.exp = ex; e.mask = mk; e.name = nm;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [8:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_wen, memwb_bubble,
             halted, mem_timeout};
      checks++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        errors++;
        $display("FAIL %s: got %b required %b (mask %b)", e.name, act, e.exp, e.mask);
      end else begin
        $display("ok   %s: %b", e.name, act);
      end
    end
  end

  initial begin
    rst = 1'b1; ifid_opcode = 4'h0; ifid_rs = 4'h0; ifid_rt = 4'h0; ifid_uses_rt = 1'b0;
    idex_memread = 1'b0; idex_rd = 4'h0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    // Reset with hazards present: all controls held low
    idle_in(); s_rst = 1'b1; s_mq = 1'b1; s_mr = 1'b1; s_rd = 4'd3; s_rs = 4'd3; s_br = 1'b1;
    cyc(E_ZERO, M_RST, "reset_0");
    cyc(E_ZERO, M_ALL, "reset_1");
    idle_in();
    cyc(E_RUN, M_ALL, "run_idle");

    // Load-use detection
    s_mr = 1'b1; s_rd = 4'd3; s_rs = 4'd3;
    cyc(E_LU, M_ALL, "lu_rs");
    s_mr = 1'b0;
    cyc(E_RUN, M_ALL, "lu_release");
    s_mr = 1'b1; s_rd = 4'd5; s_rs = 4'd1; s_rt = 4'd5; s_ur = 1'b1;
    cyc(E_LU, M_ALL, "lu_rt");
    s_rd = 4'd0; s_rs = 4'd0; s_rt = 4'd0;
    cyc(E_RUN, M_ALL, "lu_rd_zero");
    s_rd = 4'd6; s_rt = 4'd6; s_ur = 1'b0; s_rs = 4'd2;
    cyc(E_RUN, M_ALL, "lu_rt_unused");
    s_mr = 1'b0; s_rd = 4'd2;
    cyc(E_RUN, M_ALL, "no_memread");

    // Memory freeze for 5 cycles (long enough to trip the timeout, so that bit is masked)
    idle_in(); s_mq = 1'b1;
    repeat (5) cyc(E_MST, M_NOTO, "mem_stall");
    s_my = 1'b1;
    cyc(E_RUN, M_NOTO, "mem_release");

    // Memory freeze beats load-use and branch; then load-use, then the held branch
    idle_in(); s_mq = 1'b1; s_mr = 1'b1; s_rd = 4'd3; s_rs = 4'd3; s_br = 1'b1;
    repeat (5) cyc(E_MST, M_NOTO, "mem_over_lu_br");
    s_my = 1'b1;
    cyc(E_LU, M_NOTO, "lu_after_mem");
    idle_in(); s_br = 1'b1;
    cyc(E_BR, M_NOTO, "br_after_lu");
    idle_in(); s_rst = 1'b1;
    cyc(E_ZERO, M_RST, "reset_mid");
    idle_in();
    cyc(E_RUN, M_ALL, "run_after_reset");

    // Branch coinciding with load-use
    s_br = 1'b1; s_mr = 1'b1; s_rd = 4'd4; s_rs = 4'd4;
    cyc(E_LU, M_ALL, "br_lu_cycle1");
    s_mr = 1'b0;
    cyc(E_BR, M_ALL, "br_lu_cycle2");
    idle_in();
    cyc(E_RUN, M_ALL, "run_idle2");
    s_br = 1'b1;
    cyc(E_BR, M_ALL, "br_only");

    // HLT decode, drain with one memory stall, halt after five cycles
    idle_in(); s_op = 4'hF;
    cyc(E_DRN, M_ALL, "hlt_decode");
    idle_in();
    cyc(E_DRN, M_ALL, "drain_c1");
    s_mq = 1'b1;
    cyc(E_MST, M_ALL, "drain_stall");
    idle_in(); s_mr = 1'b1; s_rd = 4'd3; s_rs = 4'd3; s_br = 1'b1;
    cyc(E_DRN, M_ALL, "drain_ignores_hz");
    idle_in();
    cyc(E_DRN, M_ALL, "drain_c4");
    cyc(E_HALT, M_ALL, "halted");
    s_br = 1'b1; s_op = 4'hF;
    cyc(E_HALT, M_ALL, "halt_hold");
    idle_in(); s_rst = 1'b1;
    cyc(E_ZERO, M_RST, "halt_reset");
    idle_in();
    cyc(E_RUN, M_ALL, "run_after_halt");

    // Memory timeout after 4 stall cycles; cycle 5 is the latch cycle and is not pinned
    idle_in(); s_mq = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 4)      cyc(E_MST, M_ALL, "timeout_pre");
      else if (i == 5) cyc(E_MST, M_NOTO, "timeout_edge");
      else             cyc(E_MST | E_TO, M_ALL, "timeout_set");
    end
    idle_in();
    cyc(E_RUN | E_TO, M_ALL, "timeout_sticky1");
    cyc(E_RUN | E_TO, M_ALL, "timeout_sticky2");
    s_rst = 1'b1;
    cyc(E_ZERO, M_RST, "timeout_reset");
    idle_in();
    cyc(E_RUN, M_ALL, "timeout_cleared");

    // Let the monitor drain the scoreboard within a bounded number of cycles
    begin
      int budget;
      budget = 10;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb_q.size() > 0) begin
        errors++;
        $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
